// File: rtl/comp_unary_tx.sv
// Serial unary (thermometer) frame transmitter: a count k becomes FRAME bits, k ones then zeros, LSB-first.
// Optional parallel tap of the frame: define COMP_UNARY_THERM_EN to add out_therm.
module comp_unary_tx #(
  parameter  int FRAME = 5,
  localparam int CW    = $clog2(FRAME + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
`ifdef COMP_UNARY_THERM_EN
  output logic [FRAME-1:0] out_therm,
`endif
  output logic          ovf
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [CW:0] FRAME_C = (CW+1)'(FRAME);
  localparam logic [CW:0] LAST_C  = FRAME_C - {{CW{1'b0}}, 1'b1};

  state_t        state_r;
  logic [CW-1:0] idx_r;
  logic [CW-1:0] cnt_r;

  logic          in_hs_s;
  logic          out_hs_s;
  logic [CW:0]   count_ext_s;
  logic [CW:0]   load_cnt_s;
  logic [CW:0]   next_idx_s;

  // Accept only when idle or when the last bit leaves this very cycle
  assign in_ready    = rst_n && ((state_r == IDLE) ||
                                 ((state_r == SEND) && out_last && out_ready));
  assign in_hs_s     = in_valid && in_ready;
  assign out_hs_s    = out_valid && out_ready;
  assign count_ext_s = {1'b0, in_count};
  assign load_cnt_s  = (count_ext_s > FRAME_C) ? FRAME_C : count_ext_s;
  assign next_idx_s  = {1'b0, idx_r} + {{CW{1'b0}}, 1'b1};

  // Frame sequencer with registered bit/last/valid/overflow outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (in_hs_s) begin
        state_r   <= SEND;
        idx_r     <= '0;
        cnt_r     <= load_cnt_s[CW-1:0];
        out_valid <= 1'b1;
        out_bit   <= (load_cnt_s != '0);
        out_last  <= 1'b0;
        ovf       <= (count_ext_s > FRAME_C);
      end else if (out_hs_s) begin
        if (out_last) begin
          state_r   <= IDLE;
          idx_r     <= '0;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          idx_r    <= next_idx_s[CW-1:0];
          out_bit  <= (next_idx_s < {1'b0, cnt_r});
          out_last <= (next_idx_s == LAST_C);
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

`ifdef COMP_UNARY_THERM_EN
  function automatic logic [FRAME-1:0] therm_f(input logic [CW:0] k);
    logic [FRAME-1:0] v;
    v = '0;
    for (int i = 0; i < FRAME; i++) begin
      v[i] = ((CW+1)'(i) < k);
    end
    return v;
  endfunction

  // Parallel tap: loaded with the frame at the load edge, cleared when the frame ends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_therm <= '0;
    end else if (in_hs_s) begin
      out_therm <= therm_f(load_cnt_s);
    end else if (out_hs_s && out_last) begin
      out_therm <= '0;
    end else begin
      out_therm <= out_therm;
    end
  end
`endif

endmodule

// File: tb/tb_comp_unary_tx.sv
// Directed bench for comp_unary_tx (FRAME=5): frame contents, back-to-back, overflow, stall, reset.
module tb_comp_unary_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       ovf;
`ifdef COMP_UNARY_THERM_EN
  logic [4:0] out_therm;
`endif

  int total = 0;
  int bad   = 0;

  comp_unary_tx #(.FRAME(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_last(out_last),
`ifdef COMP_UNARY_THERM_EN
    .out_therm(out_therm),
`endif
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_count = 3'd0; out_ready = 1'b0;
    step(); step();
    total++;
    if ({out_valid, out_bit, out_last, ovf, in_ready} !== 5'b00000) begin
      bad++; $display("FAIL reset_outputs got=%b want=00000", {out_valid, out_bit, out_last, ovf, in_ready});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [4:0] exp_bits;
    int ones;
    exp_bits = 5'b00111; ones = 0;
    in_count = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, out_bit, out_last, in_ready} !== {1'b1, exp_bits[i], (i == 4), (i == 4)}) begin
        bad++; $display("FAIL basic_bit%0d got v/b/l/r=%b want=%b", i,
                        {out_valid, out_bit, out_last, in_ready}, {1'b1, exp_bits[i], (i == 4), (i == 4)});
      end
      if (out_bit === 1'b1) ones++;
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_end_valid got=%b want=0", out_valid); end
    total++;
    if (ones != 3) begin bad++; $display("FAIL basic_comp53 got=%0d want=3", ones); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_bits;
    exp_bits = 10'b11111_00000;
    in_count = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_count = 3'd5;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) in_valid = 1'b0;
      total++;
      if ({out_valid, out_bit, out_last} !== {1'b1, exp_bits[i], (i % 5 == 4)}) begin
        bad++; $display("FAIL b2b_bit%0d got v/b/l=%b want=%b", i,
                        {out_valid, out_bit, out_last}, {1'b1, exp_bits[i], (i % 5 == 4)});
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_overflow();
    int ones;
    ones = 0;
    in_count = 3'd7; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, out_bit, out_last, ovf} !== {1'b1, 1'b1, (i == 4), (i == 0)}) begin
        bad++; $display("FAIL ovf_bit%0d got v/b/l/o=%b want=%b", i,
                        {out_valid, out_bit, out_last, ovf}, {1'b1, 1'b1, (i == 4), (i == 0)});
      end
      if (out_bit === 1'b1) ones++;
      step();
    end
    total++;
    if (ones != 5) begin bad++; $display("FAIL ovf_comp53 got=%0d want=5", ones); end
  endtask

  task automatic test_stall();
    logic [4:0] exp_bits;
    int hs;
    exp_bits = 5'b00011; hs = 0;
    in_count = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && hs < 5; c++) begin
      out_ready = (c % 3 == 0);
      #1;
      total++;
      if ({out_valid, out_bit, out_last, in_ready} !==
          {1'b1, exp_bits[hs], (hs == 4), (hs == 4) && out_ready}) begin
        bad++; $display("FAIL stall_c%0d got v/b/l/r=%b want=%b", c, {out_valid, out_bit, out_last, in_ready},
                        {1'b1, exp_bits[hs], (hs == 4), (hs == 4) && out_ready});
      end
      if (out_ready) hs++;
      step();
    end
    total++;
    if (hs != 5 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_done got hs=%0d valid=%b want hs=5 valid=0", hs, out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [4:0] exp_bits;
    in_count = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    total++;
    if ({out_valid, out_bit, out_last} !== 3'b110) begin
      bad++; $display("FAIL mrst_idx2 got=%b want=110", {out_valid, out_bit, out_last});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready_low got=%b want=0", in_ready); end
    step();
    total++;
    if ({out_valid, out_bit, out_last, ovf, in_ready} !== 5'b00000) begin
      bad++; $display("FAIL mrst_outputs got=%b want=00000", {out_valid, out_bit, out_last, ovf, in_ready});
    end
    rst_n = 1'b1;
    exp_bits = 5'b00001;
    in_count = 3'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, out_bit, out_last} !== {1'b1, exp_bits[i], (i == 4)}) begin
        bad++; $display("FAIL mrst_k1_bit%0d got=%b want=%b", i,
                        {out_valid, out_bit, out_last}, {1'b1, exp_bits[i], (i == 4)});
      end
      step();
    end
  endtask

`ifdef COMP_UNARY_THERM_EN
  task automatic test_therm();
    in_count = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_therm !== 5'b00111) begin bad++; $display("FAIL therm_bit%0d got=%b want=00111", i, out_therm); end
      step();
    end
    total++;
    if (out_therm !== 5'b00000) begin bad++; $display("FAIL therm_clear got=%b want=00000", out_therm); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_mid_reset();
`ifdef COMP_UNARY_THERM_EN
    test_therm();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
